// File: rtl/ifetch_unit.sv
// Instruction fetch unit: credit-limited in-order fetch, PC tag queue and a
// DEPTH-entry decode queue; redirects flush the queue and drain stale responses.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] pc_decode,
    output logic [31:0] instr_decode
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    logic [31:0] fpc_q, fpc_d;
    cnt_t        inflight_q, inflight_d;
    cnt_t        drop_q, drop_d;
    cnt_t        count_q, count_d;
    ptr_t        rd_q, rd_d, wr_q, wr_d;
    ptr_t        trd_q, trd_d, twr_q, twr_d;
    logic [31:0] hpc_q, hpc_d, hins_q, hins_d;
    logic [31:0] qpc_q  [DEPTH];
    logic [31:0] qins_q [DEPTH];
    logic [31:0] tag_q  [DEPTH];
    logic        req_fire, live_rsp, push, pop;

    // inflight counts every accepted, unanswered request, including ones to drop
    assign imem_req_valid = rst_n && !redirect_valid &&
                            ((32'(inflight_q) + 32'(count_q)) < DEPTH);
    assign imem_req_addr  = {fpc_q[31:2], 2'b00};
    assign dec_valid      = (count_q != '0);
    assign pc_decode      = hpc_q;
    assign instr_decode   = hins_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign live_rsp = imem_rsp_valid && (drop_q == '0);
    assign push     = live_rsp && !redirect_valid;
    assign pop      = dec_valid && dec_ready && !redirect_valid;

    always_comb begin
        fpc_d = fpc_q;
        if (redirect_valid) begin
            fpc_d = redirect_pc & 32'hFFFF_FFFC;
        end else if (req_fire) begin
            fpc_d = fpc_q + 32'd4;
        end

        inflight_d = inflight_q + cnt_t'(req_fire) - cnt_t'(imem_rsp_valid);

        drop_d = drop_q;
        if (redirect_valid) begin
            drop_d = inflight_q - cnt_t'(imem_rsp_valid);
        end else if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - cnt_t'(1);
        end

        trd_d   = trd_q;
        twr_d   = twr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (redirect_valid) begin
            trd_d   = '0;
            twr_d   = '0;
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (req_fire) twr_d = ptr_inc(twr_q);
            if (live_rsp) trd_d = ptr_inc(trd_q);
            if (push)     wr_d  = ptr_inc(wr_q);
            if (pop)      rd_d  = ptr_inc(rd_q);
            count_d = count_q + cnt_t'(push) - cnt_t'(pop);
        end

        // Head registers track what the queue head will be after this cycle
        hpc_d  = hpc_q;
        hins_d = hins_q;
        if (pop && (count_q > cnt_t'(1))) begin
            hpc_d  = qpc_q[ptr_inc(rd_q)];
            hins_d = qins_q[ptr_inc(rd_q)];
        end else if (push && (pop || (count_q == '0))) begin
            hpc_d  = tag_q[trd_q];
            hins_d = imem_rsp_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q      <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            trd_q      <= '0;
            twr_q      <= '0;
            hpc_q      <= '0;
            hins_q     <= '0;
        end else begin
            fpc_q      <= fpc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            trd_q      <= trd_d;
            twr_q      <= twr_d;
            hpc_q      <= hpc_d;
            hins_q     <= hins_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            qpc_q[wr_q]  <= tag_q[trd_q];
            qins_q[wr_q] <= imem_rsp_data;
        end
        if (req_fire) begin
            tag_q[twr_q] <= imem_req_addr;
        end
    end
endmodule
